pkt_rd_sched: RTL and testbench
===============================

PKT_RD_SCHED -- requirements
Module: pkt_rd_sched

Interface
REQ-001 Parameter DATA_W, 8, payload width per RAM word.
REQ-002 Parameter ADDR_W, 8, per-queue RAM address width; depth = 2^ADDR_W; pointers wrap naturally.
REQ-003 Parameter NQ, 4, queue count; queue 0 highest priority, NQ-1 lowest; QW = max(1,clog2(NQ)).
REQ-004 Parameter RUN_LIMIT, 5, max consecutive packets from one queue while another is non-empty; 0 disables the limit.
REQ-005 Ports, in order:
- clk, in, 1, clock.
- rst_n, in, 1, reset: asynchronous, active-low.
- wr_ptr, in, NQ*ADDR_W, per-queue write pointer; queue q in slice q.
- ram_ren, out, NQ, per-queue RAM read enable.
- ram_raddr, out, NQ*ADDR_W, per-queue read address.
- ram_rdata, in, NQ*(DATA_W+2), per-queue word {sop, eop, data}; valid 1 cycle after ren.
- rd_ptr, out, NQ*ADDR_W, committed read pointer per queue, for writer full detection.
- out_valid, out, 1, output word valid.
- out_ready, in, 1, downstream accept.
- out_data, out, DATA_W, payload.
- out_sop, out, 1, first word of packet.
- out_eop, out, 1, last word of packet.
- out_qid, out, QW, source queue.
- busy, out, 1, state != IDLE or output buffer non-empty.

Function
REQ-006 Queue q non-empty when rd_ptr[q] != wr_ptr[q].
REQ-007 FSM states IDLE, SEND, FLUSH; at most one ram_ren bit high per cycle.
REQ-008 IDLE: if any queue non-empty -> SEND the same edge, latching winner cur_q; else stay IDLE.
REQ-009 Winner = highest-priority non-empty queue, unless RUN_LIMIT>0, run_cnt==RUN_LIMIT, that queue == last_q and another queue is non-empty; then winner = highest-priority non-empty queue != last_q.
REQ-010 On each grant: if winner == last_q, run_cnt increments, saturating at RUN_LIMIT; else run_cnt=1; last_q=winner.
REQ-011 SEND: a read is issued from iss_ptr[cur_q] when iss_ptr != wr_ptr[cur_q] and (buf_cnt + inflight - pop) < 2; iss_ptr increments on issue. pop = out_valid & out_ready.
REQ-012 Output buffer is 2 entries deep; a returned word is written to it 1 cycle after issue; out_* reflect its head; no word is dropped or duplicated under any out_ready pattern.
REQ-013 Returned word with eop=1: rd_ptr[cur_q] and iss_ptr[cur_q] both become eop address + 1; next state is FLUSH if a read is still in flight, else IDLE.
REQ-014 FLUSH: the in-flight returned word is discarded and does not enter the buffer; rd_ptr is unchanged; next state IDLE.
REQ-015 Returned non-eop word: rd_ptr[cur_q] = its address + 1.
REQ-016 Queue runs empty mid-packet (iss_ptr == wr_ptr): stall in SEND with no ren; resume when wr_ptr advances; no timeout.
REQ-017 Non-selected queues: iss_ptr tracks rd_ptr; ram_raddr[q] = iss_ptr[q] at all times.
REQ-018 Pointer arithmetic is modulo 2^ADDR_W; address 2^ADDR_W-1 wraps to 0.
REQ-019 Word passes unchanged: out_data/out_sop/out_eop taken from RAM bits; out_qid = cur_q at issue.
REQ-020 Throughput in SEND with out_ready=1 and data available: 1 word/cycle after a 1-cycle fill.

Reset
REQ-021 rst_n low: state IDLE; all rd_ptr/iss_ptr = 0; buffer empty; inflight = 0; run_cnt = 0; last_q = 0.
REQ-022 rst_n low: all outputs 0, including ram_ren, out_valid and busy.
REQ-023 Reset asserted mid-packet aborts the packet; after release, operation resumes from pointer 0.

Verification
REQ-024 Single 3-word packet in q2, wr_ptr[2]=3, out_ready=1 -> words out on 3 consecutive cycles; sop on word 0, eop on word 2; out_qid=2; rd_ptr[2]=3; then IDLE.
REQ-025 q0 loaded with 8 one-word packets, q3 with 1 packet, RUN_LIMIT=5 -> grant order q0×5, q3, q0×3.
REQ-026 4-word packet, out_ready toggling 1010... -> 4 words delivered in order, no loss or duplication, buffer occupancy never exceeds 2.
REQ-027 Back-to-back 2-word packets in q1 -> word following the eop discarded via FLUSH; next packet starts at eop address+1 with sop=1.
REQ-028 Packet spans address 255->0 (ADDR_W=8) -> correct data; rd_ptr wraps to small value.
REQ-029 rst_n pulsed low mid-packet -> all outputs 0 immediately; post-release single packet at address 0 delivered correctly.

Source files
------------

// File: rtl/pkt_rd_sched.sv
// rtl/pkt_rd_sched.sv - priority packet read scheduler over per-queue RAMs
// Streams one packet at a time from the granted queue through a 2-entry output buffer.
module pkt_rd_sched #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int NQ        = 4,
  parameter int RUN_LIMIT = 5,
  localparam int QW       = (NQ > 1) ? $clog2(NQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NQ*ADDR_W-1:0]     wr_ptr,
  output logic [NQ-1:0]            ram_ren,
  output logic [NQ*ADDR_W-1:0]     ram_raddr,
  input  logic [NQ*(DATA_W+2)-1:0] ram_rdata,
  output logic [NQ*ADDR_W-1:0]     rd_ptr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_sop,
  output logic                     out_eop,
  output logic [QW-1:0]            out_qid,
  output logic                     busy
);
  localparam int WW = DATA_W + 2;
  localparam int CW = (RUN_LIMIT > 0) ? $clog2(RUN_LIMIT + 1) : 1;

  typedef enum logic [1:0] {IDLE, SEND, FLUSH} state_e;

  state_e            state_q, state_d;
  logic [QW-1:0]     cur_q_q, cur_q_d;
  logic [ADDR_W-1:0] rd_ptr_q  [NQ];
  logic [ADDR_W-1:0] rd_ptr_d  [NQ];
  logic [ADDR_W-1:0] iss_ptr_q [NQ];
  logic [ADDR_W-1:0] iss_ptr_d [NQ];
  logic              infl_q, infl_d;
  logic [ADDR_W-1:0] infl_addr_q, infl_addr_d;
  logic [QW-1:0]     infl_qid_q, infl_qid_d;
  logic [CW-1:0]     run_cnt_q, run_cnt_d;
  logic [QW-1:0]     last_q_q, last_q_d;

  logic [WW-1:0]     buf_word_q [2];
  logic [QW-1:0]     buf_qid_q  [2];
  logic              buf_rd_q, buf_wr_q;
  logic [1:0]        buf_cnt_q;

  logic [ADDR_W-1:0] wr_ptr_a [NQ];
  logic [WW-1:0]     rdata_a  [NQ];
  logic [NQ-1:0]     nonempty;
  logic [NQ-1:0]     ren;
  logic [QW-1:0]     first_q, alt_q, win_q;
  logic              first_ok, alt_ok, limit_hit;
  logic [WW-1:0]     ret_word;
  logic              push, pop, issue;
  logic [2:0]        occ;

  always_comb begin
    ram_raddr = '0;
    rd_ptr    = '0;
    nonempty  = '0;
    for (int q = 0; q < NQ; q++) begin
      wr_ptr_a[q]                   = wr_ptr[q*ADDR_W +: ADDR_W];
      rdata_a[q]                    = ram_rdata[q*WW +: WW];
      ram_raddr[q*ADDR_W +: ADDR_W] = iss_ptr_q[q];
      rd_ptr[q*ADDR_W +: ADDR_W]    = rd_ptr_q[q];
      nonempty[q]                   = rd_ptr_q[q] != wr_ptr[q*ADDR_W +: ADDR_W];
    end
  end

  // Fairness override: once the repeat winner has used up its run, pass to the next busy queue.
  always_comb begin
    first_q  = '0;
    first_ok = 1'b0;
    alt_q    = '0;
    alt_ok   = 1'b0;
    for (int q = 0; q < NQ; q++) begin
      if (nonempty[q] && !first_ok) begin
        first_q  = QW'(q);
        first_ok = 1'b1;
      end
      if (nonempty[q] && !alt_ok && (QW'(q) != last_q_q)) begin
        alt_q  = QW'(q);
        alt_ok = 1'b1;
      end
    end
    limit_hit = (RUN_LIMIT > 0) && (run_cnt_q == CW'(RUN_LIMIT)) &&
                (first_q == last_q_q) && alt_ok;
    win_q     = limit_hit ? alt_q : first_q;
  end

  assign out_valid = buf_cnt_q != 2'd0;
  assign pop       = out_valid & out_ready;
  assign occ       = {1'b0, buf_cnt_q} + {2'b00, infl_q} - {2'b00, pop};
  assign ret_word  = rdata_a[infl_qid_q];

  always_comb begin
    state_d     = state_q;
    cur_q_d     = cur_q_q;
    rd_ptr_d    = rd_ptr_q;
    iss_ptr_d   = iss_ptr_q;
    infl_d      = 1'b0;
    infl_addr_d = infl_addr_q;
    infl_qid_d  = infl_qid_q;
    run_cnt_d   = run_cnt_q;
    last_q_d    = last_q_q;
    ren         = '0;
    push        = 1'b0;
    issue       = 1'b0;
    case (state_q)
      IDLE: begin
        if (first_ok) begin
          state_d  = SEND;
          cur_q_d  = win_q;
          last_q_d = win_q;
          if (win_q == last_q_q) begin
            run_cnt_d = (run_cnt_q < CW'(RUN_LIMIT)) ? run_cnt_q + CW'(1) : run_cnt_q;
          end else begin
            run_cnt_d = CW'(1);
          end
        end
      end
      SEND: begin
        if ((iss_ptr_q[cur_q_q] != wr_ptr_a[cur_q_q]) && (occ < 3'd2)) begin
          issue                = 1'b1;
          ren[cur_q_q]         = 1'b1;
          iss_ptr_d[cur_q_q]   = iss_ptr_q[cur_q_q] + ADDR_W'(1);
          infl_d               = 1'b1;
          infl_addr_d          = iss_ptr_q[cur_q_q];
          infl_qid_d           = cur_q_q;
        end
        if (infl_q) begin
          push              = 1'b1;
          rd_ptr_d[cur_q_q] = infl_addr_q + ADDR_W'(1);
          // End of packet rewinds the issue pointer past any speculative read.
          if (ret_word[DATA_W]) begin
            iss_ptr_d[cur_q_q] = infl_addr_q + ADDR_W'(1);
            state_d            = issue ? FLUSH : IDLE;
          end
        end
      end
      FLUSH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    for (int q = 0; q < NQ; q++) begin
      if ((state_q != SEND) || (QW'(q) != cur_q_q)) iss_ptr_d[q] = rd_ptr_q[q];
    end
  end

  assign ram_ren = ren;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cur_q_q     <= '0;
      infl_q      <= 1'b0;
      infl_addr_q <= '0;
      infl_qid_q  <= '0;
      run_cnt_q   <= '0;
      last_q_q    <= '0;
      for (int q = 0; q < NQ; q++) begin
        rd_ptr_q[q]  <= '0;
        iss_ptr_q[q] <= '0;
      end
    end else begin
      state_q     <= state_d;
      cur_q_q     <= cur_q_d;
      infl_q      <= infl_d;
      infl_addr_q <= infl_addr_d;
      infl_qid_q  <= infl_qid_d;
      run_cnt_q   <= run_cnt_d;
      last_q_q    <= last_q_d;
      rd_ptr_q    <= rd_ptr_d;
      iss_ptr_q   <= iss_ptr_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_word_q[0] <= '0;
      buf_word_q[1] <= '0;
      buf_qid_q[0]  <= '0;
      buf_qid_q[1]  <= '0;
      buf_rd_q      <= 1'b0;
      buf_wr_q      <= 1'b0;
      buf_cnt_q     <= 2'd0;
    end else begin
      if (push) begin
        buf_word_q[buf_wr_q] <= ret_word;
        buf_qid_q[buf_wr_q]  <= infl_qid_q;
        buf_wr_q             <= ~buf_wr_q;
      end
      if (pop) buf_rd_q <= ~buf_rd_q;
      case ({push, pop})
        2'b10:   buf_cnt_q <= buf_cnt_q + 2'd1;
        2'b01:   buf_cnt_q <= buf_cnt_q - 2'd1;
        default: buf_cnt_q <= buf_cnt_q;
      endcase
    end
  end

  assign out_data = buf_word_q[buf_rd_q][DATA_W-1:0];
  assign out_eop  = buf_word_q[buf_rd_q][DATA_W];
  assign out_sop  = buf_word_q[buf_rd_q][DATA_W+1];
  assign out_qid  = buf_qid_q[buf_rd_q];
  assign busy     = (state_q != IDLE) || (buf_cnt_q != 2'd0);

endmodule

// File: tb/tb_pkt_rd_sched.sv
// tb/tb_pkt_rd_sched.sv - self-checking bench for pkt_rd_sched
// Packet-level scoreboard model plus directed scenarios with literal expectations.
module tb_pkt_rd_sched;
  localparam int DW = 8;
  localparam int AW = 8;
  localparam int NQ = 4;
  localparam int RL = 5;
  localparam int QW = 2;
  localparam int WW = DW + 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [AW-1:0]   wr [NQ];
  logic [NQ*AW-1:0] wr_ptr;
  logic [NQ-1:0]   ram_ren;
  logic [NQ*AW-1:0] ram_raddr;
  logic [NQ*WW-1:0] ram_rdata;
  logic [NQ*AW-1:0] rd_ptr;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [DW-1:0]   out_data;
  logic            out_sop;
  logic            out_eop;
  logic [QW-1:0]   out_qid;
  logic            busy;

  logic [WW-1:0]   mem [NQ][256];
  logic [WW-1:0]   rdata_r [NQ];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [11:0] exp_q [$];
  logic [11:0] pword [$];
  int          pcyc  [$];
  int          glog  [$];
  logic [11:0] act_w, exp_w;

  logic [AW-1:0] m_rd [NQ];
  logic [AW-1:0] tgt  [NQ];
  int            m_last, m_run;

  pkt_rd_sched #(.DATA_W(DW), .ADDR_W(AW), .NQ(NQ), .RUN_LIMIT(RL)) dut (
    .clk(clk), .rst_n(rst_n), .wr_ptr(wr_ptr), .ram_ren(ram_ren), .ram_raddr(ram_raddr),
    .ram_rdata(ram_rdata), .rd_ptr(rd_ptr), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sop(out_sop), .out_eop(out_eop), .out_qid(out_qid), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign wr_ptr    = {wr[3], wr[2], wr[1], wr[0]};
  assign ram_rdata = {rdata_r[3], rdata_r[2], rdata_r[1], rdata_r[0]};

  always @(posedge clk) begin
    for (int q = 0; q < NQ; q++)
      if (ram_ren[q]) rdata_r[q] <= mem[q][ram_raddr[q*AW +: AW]];
  end

  task automatic check(input bit ok, input string name, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [AW-1:0] get_rd(input int q);
    return rd_ptr[q*AW +: AW];
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      check($countones(ram_ren) <= 1, "ren_onehot", longint'(ram_ren), 0);
      if (out_valid && out_ready) begin
        act_w = {out_qid, out_sop, out_eop, out_data};
        if (exp_q.size() == 0) begin
          check(1'b0, "extra_word", act_w, 0);
        end else begin
          exp_w = exp_q.pop_front();
          check(act_w == exp_w, "word", act_w, exp_w);
        end
        pword.push_back(act_w);
        pcyc.push_back(cyc);
        if (out_sop) glog.push_back(int'(out_qid));
      end
    end
  end

  // Packet-level scheduler: walk whole packets in grant order from the bench's RAM image.
  task automatic model_run();
    int first, win, n;
    logic [WW-1:0] w;
    forever begin
      first = -1;
      for (int q = 0; q < NQ; q++)
        if (first < 0 && m_rd[q] != tgt[q]) first = q;
      if (first < 0) break;
      win = first;
      if (RL > 0 && m_run == RL && first == m_last) begin
        for (int q = NQ - 1; q >= 0; q--)
          if (q != m_last && m_rd[q] != tgt[q]) win = q;
      end
      m_run  = (win == m_last) ? ((m_run < RL) ? m_run + 1 : m_run) : 1;
      m_last = win;
      n = 0;
      do begin
        w = mem[win][m_rd[win]];
        exp_q.push_back({2'(win), w});
        m_rd[win] = m_rd[win] + 1'b1;
        n++;
      end while (!w[DW] && n < 256);
    end
  endtask

  task automatic load_pkt(input int q, input logic [AW-1:0] start, input int len,
                          input logic [DW-1:0] seed);
    logic [AW-1:0] a;
    a = start;
    for (int i = 0; i < len; i++) begin
      mem[q][a] = {(i == 0), (i == len - 1), seed + DW'(i * 13)};
      a = a + 1'b1;
    end
  endtask

  task automatic clear_logs();
    pword.delete();
    pcyc.delete();
    glog.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    out_ready = 1'b0;
    for (int q = 0; q < NQ; q++) begin
      wr[q] = '0;
      tgt[q] = '0;
      m_rd[q] = '0;
    end
    m_last = 0;
    m_run = 0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    clear_logs();
  endtask

  task automatic start_all();
    model_run();
    for (int q = 0; q < NQ; q++) wr[q] = tgt[q];
  endtask

  task automatic run(input int budget, input int mode, input string name);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    while (!done && n < budget) begin
      case (mode)
        1:       out_ready = ~n[0];
        2:       out_ready = (n % 3) != 2;
        default: out_ready = 1'b1;
      endcase
      @(posedge clk);
      #1;
      n++;
      done = (exp_q.size() == 0) && !busy;
    end
    check(done, name, n, budget);
  endtask

  task automatic check_zero(input string tag);
    check(ram_ren == '0, {tag, "_ren"}, ram_ren, 0);
    check(ram_raddr == '0, {tag, "_raddr"}, ram_raddr, 0);
    check(rd_ptr == '0, {tag, "_rd_ptr"}, rd_ptr, 0);
    check(out_valid == 1'b0, {tag, "_valid"}, out_valid, 0);
    check(out_data == '0, {tag, "_data"}, out_data, 0);
    check({out_sop, out_eop} == 2'b00, {tag, "_sop_eop"}, {out_sop, out_eop}, 0);
    check(out_qid == '0, {tag, "_qid"}, out_qid, 0);
    check(busy == 1'b0, {tag, "_busy"}, busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int exp_g3 [9] = '{0, 0, 0, 0, 0, 3, 0, 0, 0};
    int exp_gm [4] = '{0, 1, 1, 2};
    for (int q = 0; q < NQ; q++) begin
      wr[q] = '0;
      for (int a = 0; a < 256; a++) mem[q][a] = '0;
    end

    // reset state
    repeat (2) @(posedge clk);
    #1 check_zero("reset");
    do_reset();
    repeat (3) @(posedge clk);
    #1 check(busy == 1'b0, "idle_busy", busy, 0);

    // single 3-word packet in q2
    load_pkt(2, 0, 3, 8'h40);
    tgt[2] = 3;
    start_all();
    run(50, 0, "t_single");
    check(pword.size() == 3, "single_count", pword.size(), 3);
    if (pword.size() == 3) begin
      check(pcyc[1] == pcyc[0] + 1 && pcyc[2] == pcyc[1] + 1, "single_back2back",
            pcyc[2] - pcyc[0], 2);
      check(pword[0] == 12'hA40, "single_w0", pword[0], 12'hA40);
      check(pword[1] == 12'h84D, "single_w1", pword[1], 12'h84D);
      check(pword[2] == 12'h95A, "single_w2", pword[2], 12'h95A);
    end
    check(get_rd(2) == 8'd3, "single_rd_ptr", get_rd(2), 3);

    // run limit: q0 x8 one-word packets, q3 x1
    do_reset();
    for (int i = 0; i < 8; i++) load_pkt(0, 8'(i), 1, 8'(8'h01 + i));
    load_pkt(3, 0, 1, 8'hE0);
    tgt[0] = 8;
    tgt[3] = 1;
    start_all();
    run(300, 0, "t_runlimit");
    check(glog.size() == 9, "grant_count", glog.size(), 9);
    if (glog.size() == 9)
      for (int i = 0; i < 9; i++) check(glog[i] == exp_g3[i], "grant_order", glog[i], exp_g3[i]);
    check(get_rd(0) == 8'd8 && get_rd(3) == 8'd1, "runlimit_rd_ptr", rd_ptr, 0);

    // 4-word packet with out_ready toggling 1010
    do_reset();
    load_pkt(0, 0, 4, 8'h70);
    tgt[0] = 4;
    start_all();
    run(100, 1, "t_toggle");
    check(pword.size() == 4, "toggle_count", pword.size(), 4);
    if (pword.size() == 4) begin
      check(pword[0][7:0] == 8'h70, "toggle_w0", pword[0][7:0], 8'h70);
      check(pword[1][7:0] == 8'h7D, "toggle_w1", pword[1][7:0], 8'h7D);
      check(pword[2][7:0] == 8'h8A, "toggle_w2", pword[2][7:0], 8'h8A);
      check(pword[3][7:0] == 8'h97, "toggle_w3", pword[3][7:0], 8'h97);
    end

    // back-to-back 2-word packets in q1 (flush of the word after eop)
    do_reset();
    load_pkt(1, 0, 2, 8'h10);
    load_pkt(1, 2, 2, 8'h20);
    tgt[1] = 4;
    start_all();
    run(100, 0, "t_flush");
    check(pword.size() == 4, "flush_count", pword.size(), 4);
    if (pword.size() == 4) begin
      check(pword[1] == 12'h51D, "flush_eop", pword[1], 12'h51D);
      check(pword[2] == 12'h620, "flush_next_sop", pword[2], 12'h620);
    end
    check(get_rd(1) == 8'd4, "flush_rd_ptr", get_rd(1), 4);

    // mixed priorities with out_ready pattern 110
    do_reset();
    load_pkt(0, 0, 2, 8'hB0);
    load_pkt(1, 0, 1, 8'hC0);
    load_pkt(1, 1, 3, 8'hC8);
    load_pkt(2, 0, 2, 8'hD0);
    tgt[0] = 2;
    tgt[1] = 4;
    tgt[2] = 2;
    start_all();
    run(200, 2, "t_mixed");
    check(glog.size() == 4, "mixed_grants", glog.size(), 4);
    if (glog.size() == 4)
      for (int i = 0; i < 4; i++) check(glog[i] == exp_gm[i], "mixed_order", glog[i], exp_gm[i]);
    check(pword.size() == 8, "mixed_count", pword.size(), 8);

    // queue runs dry mid-packet, then refills
    do_reset();
    load_pkt(3, 0, 5, 8'h55);
    tgt[3] = 5;
    model_run();
    wr[3] = 2;
    out_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check(busy == 1'b1, "stall_busy", busy, 1);
    check(ram_ren == '0, "stall_no_ren", ram_ren, 0);
    check(get_rd(3) == 8'd2, "stall_rd_ptr", get_rd(3), 2);
    check(pword.size() == 2, "stall_count", pword.size(), 2);
    wr[3] = 5;
    run(100, 0, "t_stall_resume");
    check(get_rd(3) == 8'd5, "stall_final_rd", get_rd(3), 5);

    // packet wrapping 255 -> 0
    do_reset();
    load_pkt(1, 0, 254, 8'h03);
    tgt[1] = 254;
    start_all();
    run(400, 0, "t_filler");
    clear_logs();
    load_pkt(1, 8'd254, 4, 8'hA0);
    tgt[1] = 2;
    start_all();
    run(100, 0, "t_wrap");
    check(pword.size() == 4, "wrap_count", pword.size(), 4);
    if (pword.size() == 4) begin
      check(pword[0] == 12'h6A0, "wrap_w254", pword[0], 12'h6A0);
      check(pword[2] == 12'h4BA, "wrap_w0", pword[2], 12'h4BA);
      check(pword[3] == 12'h5C7, "wrap_eop", pword[3], 12'h5C7);
    end
    check(get_rd(1) == 8'd2, "wrap_rd_ptr", get_rd(1), 2);

    // reset asserted mid-packet
    do_reset();
    load_pkt(2, 0, 6, 8'h90);
    tgt[2] = 6;
    start_all();
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check(pword.size() > 0 && pword.size() < 6, "midpkt_progress", pword.size(), 1);
    check_zero("midrst");
    do_reset();
    load_pkt(2, 0, 3, 8'h33);
    tgt[2] = 3;
    start_all();
    run(60, 0, "t_post_reset");
    check(pword.size() == 3, "post_count", pword.size(), 3);
    if (pword.size() == 3) check(pword[0] == 12'hA33, "post_w0", pword[0], 12'hA33);
    check(get_rd(2) == 8'd3, "post_rd_ptr", get_rd(2), 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
